spi_flash_cmd_responder: RTL
============================

Name: spi_flash_cmd_responder

Overview:
- Flash-side SPI responder, clocked by the system clock.
- Decodes SPI mode-0 command frames from spi_master and implements the Bank Address Register commands: BRWR (8'h17) and BRRD (8'h16). With the optional feature, also RDID (8'h9F).
- Serves as the bench and board-bring-up stand-in for the external flash.
- Oversamples SS/SCK/MOSI, drives MISO, and reports decoded activity to local logic.

Parameters:
- BAR_RESET, 8'h00, value loaded into BAR on reset.
- BAR_WR_MASK, 8'h81, writable BAR bits (EXTADD bit7, BA24 bit0); masked bits always read 0.
- DEVICE_ID, 24'h010219, RDID response bytes, sent MS byte first.
- SYNC_STAGES, 2, flops per input synchronizer (minimum 2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- mlb  in  1  1 = MSB-first bit order, 0 = LSB-first; applies to both directions; sampled at SS falling edge
- SS  in  1  chip select, active low
- SCK  in  1  serial clock, CPOL=0
- MOSI  in  1  serial data from the master
- MISO  out  1  serial data to the master
- bar  out  8  Bank Address Register contents
- cmd_valid  out  1  one-clk pulse when a command byte is decoded
- cmd  out  8  last command byte; held until the next command
- rx_byte  out  8  last received byte of any kind
- byte_done  out  1  one-clk pulse per completed byte
- busy  out  1  high while SS is low (synchronized)

Behaviour:
- Reset values: MISO=0, bar=BAR_RESET & BAR_WR_MASK, cmd=0, rx_byte=0, cmd_valid=0, byte_done=0, busy=0, state IDLE, bit counter 0.
- Input sync: SS, SCK and MOSI each pass through SYNC_STAGES flops. Edges are detected on the synchronized SCK and SS.
- Timing requirement: SCK high and low phases each ≥ 4 clk.
- MOSI sampling: on synchronized SCK rising, with latency SYNC_STAGES+1 clk from the pin. The 3-bit counter increments per sample.
- Byte completion: on the 8th sample, rx_byte is updated and byte_done pulses in the same clk.
- MISO shifting: updates on synchronized SCK falling edges. The first bit of a response byte is driven on the falling edge that follows the 8th rising edge of the previous byte.
- MISO outside a response: 0 in IDLE, CMD, WR_DATA and IGNORE.
- FSM:
  - IDLE: on SS fall → CMD; counter cleared; mlb latched.
  - CMD: on byte complete, cmd <= byte and cmd_valid pulses.
    - 8'h17 → WR_DATA.
    - 8'h16 → RD_DATA, transmit register loaded with bar.
    - 8'h9F (feature enabled only) → RD_ID, byte index 0.
    - Any other byte → IGNORE.
  - WR_DATA: on byte complete, bar <= rx_byte & BAR_WR_MASK (bar updates in the byte_done clk) → IGNORE. Further bytes have no effect.
  - RD_DATA: bar is reloaded at every byte boundary, so bar repeats indefinitely.
  - RD_ID: sends DEVICE_ID[23:16], then [15:8], then [7:0], then 8'h00 repeated.
  - IGNORE: counts bytes; byte_done still pulses; no other effect.
- Any state: synchronized SS rise → IDLE in the next clk.
  - A partial byte is discarded: no byte_done, no bar write.
  - MISO returns to 0.
  - Reset mid-frame has the same effect, plus register reinitialisation.
- Simultaneous SS rise and 8th SCK rise in the same clk: the byte completes (byte_done, bar write if in WR_DATA), then the FSM goes to IDLE.
- A frame with zero SCK edges causes no outputs other than busy.

Optional Feature:
- Macro: SPI_FLASH_RESP_RDID_EN.
- Defined: RD_ID state and the 8'h9F decode are present, as above.
- Undefined: 8'h9F is treated as unknown and goes to IGNORE. DEVICE_ID is unused, and MISO stays 0.

Decomposition:
- Package spi_flash_pkg:
  - command constants CMD_BRWR=8'h17, CMD_BRRD=8'h16, CMD_RDID=8'h9F;
  - FSM state enum {IDLE, CMD, WR_DATA, RD_DATA, RD_ID, IGNORE}.
- One natural sub-module: spi_input_sync. It is a SYNC_STAGES synchronizer with rise/fall detect, instanced for SCK and SS; MOSI uses the plain synchronizer output.

Test Plan:
- BRWR, mlb=1: spi_master sends 8'h17 then 8'hFF in one multi-byte frame → cmd_valid once with cmd=8'h17; bar=8'h81 after the 2nd byte_done; MISO stays 0.
- BRRD after the previous test: master sends 8'h16 then 8'h00, 8'h00 → master received_data = 8'h81 for both data bytes.
- mlb=0: BRWR with data 8'h01, then BRRD → bar=8'h01; master (mlb=0) receives 8'h01.
- Abort: SS raised after 4 bits of the BRWR data byte (8'h80) → no 2nd byte_done; bar unchanged (8'h01); busy=0 within SYNC_STAGES+1 clk.
- Unknown command 8'h03 followed by 8'hAA → cmd=8'h03, FSM in IGNORE, bar unchanged, MISO=0, two byte_done pulses.
- With SPI_FLASH_RESP_RDID_EN: 8'h9F followed by 4 dummy bytes → master receives 8'h01, 8'h02, 8'h19, 8'h00. Without the macro → all 8'h00.
- Async reset asserted mid-BRRD → MISO=0 and bar=8'h00 immediately; a following BRRD returns 8'h00.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared constants and FSM state type for the SPI flash command responder.
package spi_flash_pkg;

   localparam logic [7:0] CMD_BRWR = 8'h17;
   localparam logic [7:0] CMD_BRRD = 8'h16;
   localparam logic [7:0] CMD_RDID = 8'h9F;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WR_DATA,
      RD_DATA,
      RD_ID,
      IGNORE
   } state_t;

endpackage

// File: rtl/spi_flash_cmd_responder_sync.sv
// Multi-flop input synchronizer with rise/fall detection on the synchronized level.
module spi_input_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // Shift the pin through the sync chain and remember the previous synchronized level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_q    = r_sync[SYNC_STAGES-1];
   assign o_rise = o_q & ~r_prev;
   assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_flash_cmd_responder.sv
// SPI mode-0 flash-side responder implementing the Bank Address Register
// commands (BRWR/BRRD). Define SPI_FLASH_RESP_RDID_EN to add RDID (8'h9F).
module spi_flash_cmd_responder
   import spi_flash_pkg::*;
#(
   parameter logic [7:0]  BAR_RESET   = 8'h00,
   parameter logic [7:0]  BAR_WR_MASK = 8'h81,
   parameter logic [23:0] DEVICE_ID   = 24'h010219,
   parameter int          SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mlb,
   input  logic       SS,
   input  logic       SCK,
   input  logic       MOSI,
   output logic       MISO,
   output logic [7:0] bar,
   output logic       cmd_valid,
   output logic [7:0] cmd,
   output logic [7:0] rx_byte,
   output logic       byte_done,
   output logic       busy
);

   logic                   w_ss_q, w_ss_rise, w_ss_fall;
   logic                   w_sck_q_unused, w_sck_rise, w_sck_fall;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   w_mosi;

   state_t     r_state;
   logic [2:0] r_cnt;
   logic [7:0] r_shift;
   logic [7:0] r_tx;
   logic       r_mlb;
`ifdef SPI_FLASH_RESP_RDID_EN
   logic [1:0] r_idx;
`else
   logic       w_unused_id;
   assign w_unused_id = ^DEVICE_ID;
`endif

   logic [7:0] w_rx_next, w_tx_shift;
   logic       w_byte_end, w_tx_bit, w_resp;

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
      .clk(clk), .reset(reset), .i_d(SS),
      .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
   );

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk(clk), .reset(reset), .i_d(SCK),
      .o_q(w_sck_q_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
   );

   // MOSI needs only the level, aligned with the SCK edge detect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_mosi_sync <= '0;
      else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
   end
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

   // Bit order follows the mlb value latched at frame start, in both directions.
   assign w_rx_next  = r_mlb ? {r_shift[6:0], w_mosi} : {w_mosi, r_shift[7:1]};
   assign w_tx_bit   = r_mlb ? r_tx[7] : r_tx[0];
   assign w_tx_shift = r_mlb ? {r_tx[6:0], 1'b0} : {1'b0, r_tx[7:1]};
   assign w_byte_end = w_sck_rise && (r_state != IDLE) && (r_cnt == 3'd7);
   assign w_resp     = (r_state == RD_DATA) || (r_state == RD_ID);

   // Frame FSM: byte assembly, command decode, BAR update and MISO shifting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= 3'd0;
         r_shift   <= 8'h00;
         r_tx      <= 8'h00;
         r_mlb     <= 1'b1;
         MISO      <= 1'b0;
         bar       <= BAR_RESET & BAR_WR_MASK;
         cmd_valid <= 1'b0;
         cmd       <= 8'h00;
         rx_byte   <= 8'h00;
         byte_done <= 1'b0;
         busy      <= 1'b0;
`ifdef SPI_FLASH_RESP_RDID_EN
         r_idx     <= 2'd0;
`endif
      end else begin
         cmd_valid <= 1'b0;
         byte_done <= 1'b0;
         busy      <= ~w_ss_q;
         case (r_state)
            IDLE: begin
               if (w_ss_fall) begin
                  r_state <= CMD;
                  r_cnt   <= 3'd0;
                  r_mlb   <= mlb;
                  r_tx    <= 8'h00;
               end
            end
            default: begin
               if (w_sck_rise) begin
                  r_shift <= w_rx_next;
                  r_cnt   <= r_cnt + 3'd1;
               end
               // Response bits change on SCK fall so they are stable at the master's rise.
               if (w_sck_fall) begin
                  MISO <= w_resp ? w_tx_bit : 1'b0;
                  r_tx <= w_tx_shift;
               end
               if (w_byte_end) begin
                  rx_byte   <= w_rx_next;
                  byte_done <= 1'b1;
                  case (r_state)
                     CMD: begin
                        cmd       <= w_rx_next;
                        cmd_valid <= 1'b1;
                        if (w_rx_next == CMD_BRWR) begin
                           r_state <= WR_DATA;
                        end else if (w_rx_next == CMD_BRRD) begin
                           r_state <= RD_DATA;
                           r_tx    <= bar;
                        end
`ifdef SPI_FLASH_RESP_RDID_EN
                        else if (w_rx_next == CMD_RDID) begin
                           r_state <= RD_ID;
                           r_tx    <= DEVICE_ID[23:16];
                           r_idx   <= 2'd1;
                        end
`endif
                        else begin
                           r_state <= IGNORE;
                        end
                     end
                     WR_DATA: begin
                        bar     <= w_rx_next & BAR_WR_MASK;
                        r_state <= IGNORE;
                     end
                     RD_DATA: r_tx <= bar;
`ifdef SPI_FLASH_RESP_RDID_EN
                     RD_ID: begin
                        case (r_idx)
                           2'd1:    r_tx <= DEVICE_ID[15:8];
                           2'd2:    r_tx <= DEVICE_ID[7:0];
                           default: r_tx <= 8'h00;
                        endcase
                        if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
                     end
`endif
                     default: ;
                  endcase
               end
               // SS rise ends the frame; a byte completing in the same clk is kept above.
               if (w_ss_rise) begin
                  r_state <= IDLE;
                  r_cnt   <= 3'd0;
                  r_tx    <= 8'h00;
                  MISO    <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
